// File: rtl/ext_trig_qual.sv
// ext_trig_qual: qualifies the external trigger line and emits counted events.
//
// Both asynchronous lines are synchronized. A qualified assertion must stay
// high for MIN_WIDTH consecutive synchronized samples. A one-cycle trig_pulse
// is then produced, followed by a re-arm holdoff. Events are counted in
// trig_count.
//
// Optional build macro EXT_TRIG_SELF_MASK_EN: an event that saw the board's
// own drive (self_trig) during qualification raises self_echo instead of
// trig_pulse and is not counted. With the macro undefined, self_trig is
// ignored and self_echo stays 0.
//
// Ports:
//   clk, rst     system clock; asynchronous active-high reset
//   ext_trig_in  external trigger line (async, active high)
//   self_trig    own line drive (async, active high)
//   enable       arms the qualifier
//   cnt_clr      synchronous clear of trig_count
//   trig_pulse   one-cycle qualified external trigger
//   self_echo    one-cycle pulse for an event attributed to own drive
//   trig_count   qualified external triggers since reset/clear
//   busy         registered, high while not IDLE
//
// state | meaning
// IDLE  | armed, waiting for s_ext high
// QUAL  | counting consecutive high samples
// FIRE  | output pulse cycle
// HOLD  | re-arm holdoff, waits for line low
module ext_trig_qual #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 4,
  parameter int HOLDOFF     = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_trig_in,
  input  logic             self_trig,
  input  logic             enable,
  input  logic             cnt_clr,
  output logic             trig_pulse,
  output logic             self_echo,
  output logic [CNT_W-1:0] trig_count,
  output logic             busy
);

  localparam int WW = $clog2(MIN_WIDTH + 1);
  localparam int HW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {IDLE, QUAL, FIRE, HOLD} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] ext_sync;
  logic                   s_ext, s_self, self_hit;
  logic [WW-1:0]          wcnt, wcnt_n;
  logic [HW-1:0]          hcnt, hcnt_n;
  logic                   flag, flag_n;
  logic                   fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ext_sync <= '0;
    else     ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_trig_in};
  end
  assign s_ext = ext_sync[SYNC_STAGES-1];

`ifdef EXT_TRIG_SELF_MASK_EN
  logic [SYNC_STAGES-1:0] self_sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) self_sync <= '0;
    else     self_sync <= {self_sync[SYNC_STAGES-2:0], self_trig};
  end
  assign s_self   = self_sync[SYNC_STAGES-1];
  // flag_n already includes the sample taken on the qualifying cycle
  assign self_hit = flag_n;
`else
  wire unused_self = self_trig;
  assign s_self   = 1'b0;
  assign self_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    hcnt_n  = hcnt;
    flag_n  = flag;
    fire    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && s_ext) begin
          flag_n = s_self;
          if (MIN_WIDTH == 1) begin
            state_n = FIRE;
            fire    = 1'b1;
          end else begin
            state_n = QUAL;
            wcnt_n  = WW'(1);
          end
        end
      end
      QUAL: begin
        if (!s_ext) begin
          state_n = IDLE;
          wcnt_n  = '0;
        end else begin
          flag_n = flag | s_self;
          if (wcnt == WW'(MIN_WIDTH - 1)) begin
            state_n = FIRE;
            fire    = 1'b1;
            wcnt_n  = '0;
          end else begin
            wcnt_n = wcnt + WW'(1);
          end
        end
      end
      FIRE: begin
        state_n = HOLD;
        hcnt_n  = '0;
      end
      HOLD: begin
        if (hcnt >= HW'(HOLDOFF - 1) && !s_ext) begin
          state_n = IDLE;
          hcnt_n  = '0;
        end else if (hcnt != HW'(HOLDOFF)) begin
          hcnt_n = hcnt + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    // disarm overrides everything; a FIRE already registered still shows
    if (!enable) begin
      state_n = IDLE;
      wcnt_n  = '0;
      hcnt_n  = '0;
      flag_n  = 1'b0;
      fire    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wcnt       <= '0;
      hcnt       <= '0;
      flag       <= 1'b0;
      busy       <= 1'b0;
      trig_pulse <= 1'b0;
      self_echo  <= 1'b0;
    end else begin
      state      <= state_n;
      wcnt       <= wcnt_n;
      hcnt       <= hcnt_n;
      flag       <= flag_n;
      busy       <= (state_n != IDLE);
      trig_pulse <= fire & ~self_hit;
      self_echo  <= fire & self_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             trig_count <= '0;
    else if (cnt_clr)    trig_count <= '0;
    else if (trig_pulse) trig_count <= trig_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_ext_trig_qual.sv
module tb_ext_trig_qual;

  localparam int LAT = 6;  // drive negedge to pulse-visible negedge

  logic       clk = 1'b0;
  logic       rst, ext_trig_in, self_trig, enable, cnt_clr;
  logic       trig_pulse, self_echo, busy;
  logic [3:0] trig_count;

  typedef struct {bit echo; int cyc;} exp_t;
  exp_t       sb[$];
  int         n_chk = 0, n_fail = 0, cyc = 0;
  logic [3:0] exp_cnt = '0;

  ext_trig_qual #(.SYNC_STAGES(2), .MIN_WIDTH(4), .HOLDOFF(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ext_trig_in(ext_trig_in), .self_trig(self_trig),
    .enable(enable), .cnt_clr(cnt_clr), .trig_pulse(trig_pulse),
    .self_echo(self_echo), .trig_count(trig_count), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard consumer
  always @(negedge clk) begin
    if (!rst && (trig_pulse || self_echo)) begin
      if (sb.size() == 0) chk("spurious_event", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("event_kind_echo", int'(self_echo), int'(e.echo));
        chk("event_kind_pulse", int'(trig_pulse), int'(!e.echo));
        chk("event_latency", cyc, e.cyc);
      end
    end
  end

  // call right after a negedge; line high for len cycles
  task automatic pulse_ext(input int len, input bit slf, input bit qual);
    bit echo;
`ifdef EXT_TRIG_SELF_MASK_EN
    echo = slf;
`else
    echo = 1'b0;
`endif
    ext_trig_in = 1'b1;
    self_trig   = slf;
    if (qual) begin
      sb.push_back('{echo, cyc + LAT});
      if (!echo) exp_cnt = exp_cnt + 4'd1;
    end
    repeat (len) @(negedge clk);
    ext_trig_in = 1'b0;
    self_trig   = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    gap(2);
    k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) chk({tag, "_idle_timeout"}, 1, 0);
    gap(3);
    chk({tag, "_sb_drained"}, sb.size(), 0);
    sb.delete();
    chk({tag, "_count"}, int'(trig_count), int'(exp_cnt));
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    bit done;
    rst = 1'b1; ext_trig_in = 1'b0; self_trig = 1'b0; enable = 1'b1; cnt_clr = 1'b0;
    gap(3);
    rst = 1'b0;
    chk("rst_pulse", int'(trig_pulse), 0);
    chk("rst_echo", int'(self_echo), 0);
    chk("rst_count", int'(trig_count), 0);
    chk("rst_busy", int'(busy), 0);
    gap(2);

    pulse_ext(10, 0, 1);          wait_idle("basic");
    pulse_ext(3, 0, 0);           wait_idle("glitch");

    enable = 1'b0;
    pulse_ext(10, 0, 0);          wait_idle("disabled");
    enable = 1'b1;

    pulse_ext(200, 0, 1);  gap(5);
    pulse_ext(6, 0, 1);           wait_idle("stuck_rearm");

    pulse_ext(5, 0, 1);  gap(5);
    pulse_ext(5, 0, 0);           wait_idle("spacing10");
    pulse_ext(5, 0, 1);  gap(25);
    pulse_ext(5, 0, 1);           wait_idle("spacing30");

    pulse_ext(8, 1, 1);           wait_idle("self_drive");

    // clear coincident with a pulse
    ext_trig_in = 1'b1;
    sb.push_back('{1'b0, cyc + LAT});
    done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (trig_pulse && !done) begin
        cnt_clr = 1'b1;
        done    = 1'b1;
      end else cnt_clr = 1'b0;
    end
    ext_trig_in = 1'b0;
    cnt_clr     = 1'b0;
    exp_cnt     = '0;
    chk("clr_pulse_seen", int'(done), 1);
    wait_idle("clr_coincident");

    // wrap of a 4-bit counter
    for (int i = 0; i < 15; i++) begin
      pulse_ext(6, 0, 1);
      wait_idle("wrap_step");
    end
    chk("wrap_at_15", int'(trig_count), 15);
    pulse_ext(6, 0, 1);           wait_idle("wrap");
    chk("wrap_zero", int'(trig_count), 0);

    // reset in the middle of the holdoff
    pulse_ext(6, 0, 1);           wait_idle("pre_reset");
    pulse_ext(10, 0, 1);
    chk("in_hold_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pulse", int'(trig_pulse), 0);
    chk("mid_rst_echo", int'(self_echo), 0);
    chk("mid_rst_count", int'(trig_count), 0);
    chk("mid_rst_busy", int'(busy), 0);
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    gap(2);
    pulse_ext(6, 0, 1);           wait_idle("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ext_trig_qual.md
# ext_trig_qual

Qualifies the external trigger line after the bidirectional trigger pad and delivers clean, counted trigger events to the acquisition logic. Consumes the active-high, pad-derived `ext_trig_maroc` (asynchronous to `clk`) and the board's own `pixel_trig_maroc` drive. Synchronizes both, rejects glitches, emits a one-cycle trigger pulse per qualified assertion, applies a re-arm holdoff and keeps an event count. Optionally separates echoes of this board's own drive from genuine external triggers.

## Interface
- `SYNC_STAGES`, 2 — synchronizer flops per async input, ≥2.
- `MIN_WIDTH`, 4 — consecutive synchronized high samples required to qualify, ≥1.
- `HOLDOFF`, 64 — minimum cycles after a pulse before re-arm, ≥1.
- `CNT_W`, 32 — width of `trig_count`.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `ext_trig_in`  in  1  external trigger line (pad `ext_trig_maroc`), async, active high.
- `self_trig`  in  1  own line drive (`pixel_trig_maroc`), async, active high.
- `enable`  in  1  arms the qualifier; synchronous.
- `cnt_clr`  in  1  synchronous clear of `trig_count`.
- `trig_pulse`  out  1  one-cycle qualified external trigger.
- `self_echo`  out  1  one-cycle pulse for a qualified event attributed to own drive.
- `trig_count`  out  CNT_W  qualified external triggers since reset/clear.
- `busy`  out  1  high in QUAL, FIRE or HOLD.

## Operation
- Both async inputs pass through `SYNC_STAGES`-deep synchronizers → `s_ext`, `s_self`. Chains run regardless of `enable`.
- States: IDLE, QUAL, FIRE, HOLD.
- IDLE: `s_ext`=1 and `enable`=1 → QUAL, width counter=1, self flag=`s_self`.
- QUAL: `s_ext`=0 → IDLE (glitch, no output). `s_ext`=1 → counter++, self flag |= `s_self`. Counter reaching `MIN_WIDTH` → FIRE. If `MIN_WIDTH`=1, IDLE → FIRE directly.
- FIRE (one cycle): outputs registered this cycle, then → HOLD with holdoff counter=0.
- HOLD: counter increments, saturating at `HOLDOFF`. → IDLE only on a cycle with counter ≥ `HOLDOFF`−1 and `s_ext`=0. A line stuck high therefore yields exactly one event; re-arm needs a falling then rising edge.
- `enable`=0: next state IDLE from any state, counters cleared, no pulses; an in-flight FIRE cycle still completes.
- `trig_count`: +1 on every cycle `trig_pulse`=1; wraps from 2^CNT_W−1 to 0. `cnt_clr` wins over a same-cycle increment (result 0).
- Reset: state IDLE; `trig_pulse`=0, `self_echo`=0, `trig_count`=0, `busy`=0; sync flops and counters 0.

## Timing
- `ext_trig_in` rising and held → `s_ext` high after `SYNC_STAGES` cycles (+≤1 sampling uncertainty).
- `s_ext` first high on cycle t and high through t+MIN_WIDTH−1 → FIRE outputs high on cycle t+MIN_WIDTH, exactly one cycle.
- `trig_count` updates on the cycle after `trig_pulse`.
- Minimum spacing between consecutive pulses: `MIN_WIDTH`+`HOLDOFF`+1 cycles.
- `busy` is registered and mirrors state: high from cycle t+1 until the IDLE return.

## Configuration
- `EXT_TRIG_SELF_MASK_EN` defined: an event whose self flag is set (`s_self` high on any QUAL sample) asserts `self_echo` instead of `trig_pulse` in FIRE. `trig_count` is not incremented. Holdoff still applies.
- Undefined: `self_trig` ignored; `self_echo` tied 0; every qualified event asserts `trig_pulse` and counts.

## Test plan
- SYNC=2, MIN_WIDTH=4, HOLDOFF=16; 10-cycle high on `ext_trig_in` → single `trig_pulse` 6±1 cycles after edge, `trig_count`=1.
- 3-cycle high → no pulse, `trig_count`=0, `busy` returns to 0.
- Line held high 200 cycles → exactly one pulse; after low then high ≥4 cycles, second pulse, count=2.
- Two 5-cycle pulses starting 10 cycles apart → count=1; starting 30 apart → count=2.
- `self_trig` and `ext_trig_in` high together 8 cycles → with macro: `self_echo`=1 once, `trig_pulse`=0, count unchanged; without: `trig_pulse`=1, count+1.
- CNT_W=4: 16 events → count=0. `cnt_clr` coincident with pulse → 0. `rst` asserted mid-HOLD → all outputs 0 immediately; next clean pulse qualifies normally.
